// File: rtl/multi_channel_debouncer.sv
// Multi-channel input debouncer: two-FF synchroniser per channel, shared sample
// prescaler, and a per-channel stability counter that accepts a level change.
module multi_channel_debouncer #(
    parameter int CHANNELS       = 4,
    parameter int SAMPLE_DIV     = 10,
    parameter int STABLE_SAMPLES = 4,
    parameter int INIT_LEVEL     = 0,
    parameter int DIV_W          = 28,
    parameter int CNT_W          = 8
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] signal_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_out,
    output logic [CHANNELS-1:0] fall_out,
    output logic                any_change,
    output logic                sample_tick
);

    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);
    localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_LEVEL != 0}};

    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick_q, tick_d;
    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic                any_q, any_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_q == DIV_LAST);
    end

    // Channels only advance on the cycle the registered tick is high.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick_q) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i]   = '0;
                    level_d[i] = sync2_q[i];
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            sync1_q <= INIT_VEC;
            sync2_q <= INIT_VEC;
            level_q <= INIT_VEC;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            sync1_q <= signal_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level_out   = level_q;
    assign rise_out    = rise_q;
    assign fall_out    = fall_q;
    assign any_change  = any_q;
    assign sample_tick = tick_q;

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Bench for multi_channel_debouncer: cycle model feeding a scoreboard queue,
// plus directed scenario checks (reset, press, glitch, bounce, simultaneous, reset mid-count).
module tb_multi_channel_debouncer;

    localparam int CH = 4;
    localparam int SD = 10;
    localparam int SS = 4;

    logic          clk_in = 1'b0;
    logic          rst_n  = 1'b0;
    logic [CH-1:0] signal_in = 4'hF;
    logic [CH-1:0] level_out, rise_out, fall_out;
    logic          any_change, sample_tick;

    int checks = 0;
    int errors = 0;

    multi_channel_debouncer #(
        .CHANNELS(CH), .SAMPLE_DIV(SD), .STABLE_SAMPLES(SS),
        .INIT_LEVEL(1), .DIV_W(28), .CNT_W(8)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .signal_in(signal_in),
        .level_out(level_out), .rise_out(rise_out), .fall_out(fall_out),
        .any_change(any_change), .sample_tick(sample_tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: tick derived from an edge count since reset release.
    logic [CH-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
    logic          m_any, m_tick;
    int            m_cnt [CH];
    int            m_cyc;
    logic [13:0]   exp_q [$];

    task automatic model_step();
        if (!rst_n) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_lvl = 4'hF;
            m_rise = '0; m_fall = '0; m_any = 1'b0; m_tick = 1'b0; m_cyc = 0;
            for (int c = 0; c < CH; c++) m_cnt[c] = 0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            if (m_tick) begin
                for (int c = 0; c < CH; c++) begin
                    if (m_s2[c] == m_lvl[c]) m_cnt[c] = 0;
                    else if (m_cnt[c] < SS - 1) m_cnt[c] = m_cnt[c] + 1;
                    else begin
                        m_cnt[c] = 0;
                        m_lvl[c] = m_s2[c];
                        if (m_s2[c]) m_rise[c] = 1'b1;
                        else         m_fall[c] = 1'b1;
                    end
                end
            end
            m_any  = |(m_rise | m_fall);
            m_cyc  = m_cyc + 1;
            m_tick = (m_cyc % SD == 0);
            m_s2   = m_s1;
            m_s1   = signal_in;
        end
        exp_q.push_back({m_lvl, m_rise, m_fall, m_any, m_tick});
    endtask

    always @(posedge clk_in) model_step();

    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e;
            e = exp_q.pop_front();
            check_eq("outputs", {18'd0, level_out, rise_out, fall_out, any_change, sample_tick}, {18'd0, e});
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_tick(input string tag);
        int k;
        for (k = 0; k < 2 * SD; k++) begin
            nclk(1);
            if (sample_tick) break;
        end
        if (k == 2 * SD) check_eq(tag, 0, 1);
    endtask

    initial begin
        int k, lat, rises, falls, any_cnt, c_f0, c_r3, ticks;
        logic [CH-1:0] f_pat;

        // Reset: 3 cycles low, INIT_LEVEL=1
        nclk(3);
        check_eq("rst_level", level_out, 4'hF);
        check_eq("rst_pulses", {rise_out, fall_out, any_change, sample_tick}, 0);
        rst_n = 1'b1;
        for (k = 1; k <= 30; k++) begin
            nclk(1);
            if (sample_tick) break;
        end
        check_eq("first_tick_cycle", k, SD);

        // Three channels fall together
        signal_in = 4'b0100;
        f_pat = '0; falls = 0;
        for (int i = 0; i < 80; i++) begin
            nclk(1);
            if (fall_out != 0) begin falls++; f_pat = fall_out; end
        end
        check_eq("multi_fall_pattern", f_pat, 4'b1011);
        check_eq("multi_fall_cycles", falls, 1);
        check_eq("multi_fall_level", level_out, 4'b0100);

        // Clean press on ch0
        signal_in[0] = 1'b1;
        lat = -1; rises = 0; falls = 0;
        for (int i = 1; i <= 60; i++) begin
            nclk(1);
            if (rise_out[0]) begin rises++; if (lat < 0) lat = i; end
            if (fall_out[0]) falls++;
        end
        check_eq("press_rises", rises, 1);
        check_eq("press_falls", falls, 0);
        check_eq("press_latency_ok", (lat > 0 && lat <= 2 + SD * SS + 1), 1);
        check_eq("press_level", level_out[0], 1);

        // Short glitch on ch2 between ticks
        wait_tick("glitch_tick_timeout");
        nclk(1);
        signal_in[2] = 1'b0;
        nclk(3);
        signal_in[2] = 1'b1;
        rises = 0;
        for (int i = 0; i < 50; i++) begin
            nclk(1);
            if (rise_out[2] || fall_out[2]) rises++;
        end
        check_eq("glitch_pulses", rises, 0);
        check_eq("glitch_level", level_out[2], 1);

        // Bounce on ch1 every 7 cycles, then hold high
        rises = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 7 == 0) signal_in[1] = ~signal_in[1];
            nclk(1);
            if (rise_out[1] || fall_out[1]) rises++;
        end
        check_eq("bounce_pulses", rises, 0);
        signal_in[1] = 1'b1;
        rises = 0; falls = 0;
        for (int i = 0; i < 60; i++) begin
            nclk(1);
            if (rise_out[1]) rises++;
            if (fall_out[1]) falls++;
        end
        check_eq("bounce_final_rise", rises, 1);
        check_eq("bounce_final_fall", falls, 0);

        // Simultaneous: ch0 1->0 and ch3 0->1
        signal_in = 4'b1110;
        c_f0 = -1; c_r3 = -2; any_cnt = 0; rises = 0; falls = 0;
        for (int i = 0; i < 60; i++) begin
            nclk(1);
            if (fall_out[0]) begin falls++; c_f0 = i; end
            if (rise_out[3]) begin rises++; c_r3 = i; end
            if (any_change) any_cnt++;
        end
        check_eq("simul_same_cycle", c_f0, c_r3);
        check_eq("simul_fall0_count", falls, 1);
        check_eq("simul_rise3_count", rises, 1);
        check_eq("simul_any_count", any_cnt, 1);
        check_eq("simul_level", level_out, 4'b1110);

        // Reset mid-count on ch2
        wait_tick("midrst_tick_timeout");
        signal_in[2] = 1'b0;
        falls = 0;
        for (int t = 0; t < 3; t++) begin
            wait_tick("midrst_count_timeout");
            if (fall_out[2]) falls++;
        end
        nclk(1);
        if (fall_out[2]) falls++;
        check_eq("midrst_no_early_fall", falls, 0);
        rst_n = 1'b0;
        nclk(1);
        check_eq("midrst_level", level_out, 4'hF);
        check_eq("midrst_pulses", {rise_out, fall_out, any_change, sample_tick}, 0);
        rst_n = 1'b1;
        ticks = 0;
        for (k = 0; k < 80; k++) begin
            nclk(1);
            if (fall_out[2]) break;
            if (sample_tick) ticks++;
        end
        check_eq("midrst_fall_seen", (k < 80), 1);
        check_eq("midrst_ticks_needed", ticks, SS);

        nclk(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
